// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch with a 1-cycle-latency memory interface and a small
// decode-facing FIFO; redirects flush queued and in-flight work.
module fetch_queue_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     ILEN        = 32,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_target,
  output logic                           imem_req,
  output logic [XLEN-1:0]                imem_addr,
  input  logic [ILEN-1:0]                imem_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_pc,
  output logic [ILEN-1:0]                out_instr,
  output logic                           misaligned_err,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(QUEUE_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misaligned_q, misaligned_d;
  logic [OW-1:0]   occupancy;
  logic            push, pop;

  logic [XLEN-1:0] pc_mem_q    [QUEUE_DEPTH];
  logic [ILEN-1:0] instr_mem_q [QUEUE_DEPTH];

  // Credit covers queued entries plus the one response still in flight, so a push
  // can never meet a full queue; a same-cycle pop is deliberately not credited.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    imem_req  = !reset && !redirect_valid && (occupancy < DEPTH_W);
    push      = inflight_q && !redirect_valid && !reset;
    pop       = out_valid && out_ready && !redirect_valid;
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    misaligned_d  = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d   = {redirect_target[XLEN-1:2], 2'b00};
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      misaligned_d = |redirect_target[1:0];
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_addr      = fetch_pc_q;
    out_valid      = (count_q != '0);
    out_pc         = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    out_instr      = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    misaligned_err = misaligned_q;
    queue_count    = count_q;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: expected PCs are queued as stimulus is
// applied and compared by a monitor on every accepted handshake.
module tb_fetch_queue_unit;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, redirect_valid, out_ready;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req, out_valid, misaligned_err;
  logic [XLEN-1:0] imem_addr, out_pc;
  logic [ILEN-1:0] imem_rdata, out_instr;
  logic [2:0]      queue_count;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mon_pc;
  int checks   = 0;
  int failures = 0;

  fetch_queue_unit #(.XLEN(XLEN), .ILEN(ILEN), .QUEUE_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misaligned_err (misaligned_err),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency instruction memory
  always @(posedge clk)
    imem_rdata <= imem_req ? {16'hC0DE, imem_addr[15:0]} : 32'hBAD0_BAD0;

  // Scoreboard monitor: a redirect or reset in the same cycle cancels the handshake.
  always @(negedge clk) begin
    checks++;
    if (queue_count > 3'(DEPTH)) begin
      failures++;
      $display("FAIL overflow queue_count=%0d max=%0d", queue_count, DEPTH);
    end
    if (reset === 1'b0 && redirect_valid === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop out_pc=%h expected=none", out_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        if (out_pc !== mon_pc) begin
          failures++;
          $display("FAIL pop_pc got=%h exp=%h", out_pc, mon_pc);
        end
        checks++;
        if (out_instr !== {16'hC0DE, mon_pc[15:0]}) begin
          failures++;
          $display("FAIL pop_instr got=%h exp=%h", out_instr, {16'hC0DE, mon_pc[15:0]});
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [XLEN-1:0] start, input int n);
    logic [XLEN-1:0] pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 64'd4;
    end
  endtask

  // Keeps the caller's out_ready until the scoreboard empties, then stalls decode.
  task automatic drain(input int budget, output int cycles, output bit timed_out);
    timed_out = 1'b1;
    cycles    = budget;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        out_ready = 1'b0;
        cycles    = i + 1;
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      out_ready = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned_err); end
    checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
    checks++; if (out_pc !== 64'd0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
  endtask

  task automatic test_sequential();
    int cyc; bit to;
    apply_reset();
    push_seq(64'h0, 12);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin failures++; $display("FAIL seq_first_req req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL seq_early_valid got=%b exp=0", out_valid); end
    drain(40, cyc, to);
    checks++; if (to || cyc != 14) begin failures++; $display("FAIL seq_latency cycles=%0d timeout=%0b exp=14", cyc, to); end
  endtask

  task automatic test_backpressure();
    int cyc; bit to;
    apply_reset();
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (queue_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", queue_count); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL bp_head got=%h exp=0", out_pc); end
    push_seq(64'h0, 8);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(40, cyc, to);
    checks++; if (to || cyc != 8) begin failures++; $display("FAIL bp_drain cycles=%0d timeout=%0b exp=8", cyc, to); end
  endtask

  task automatic test_branch();
    int cyc; bit to;
    apply_reset();
    push_seq(64'h0, 10);
    reset = 1'b0; out_ready = 1'b1;
    drain(40, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL br_prefix timeout=%0b exp=0", to); end
    redirect_valid = 1'b1; redirect_target = 64'h10; out_ready = 1'b1;
    push_seq(64'h10, 3);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL br_req_during got=%b exp=0", imem_req); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL br_misaligned got=%b exp=0", misaligned_err); end
    checks++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL br_flush count=%0d valid=%b exp 0/0", queue_count, out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin failures++; $display("FAIL br_req req=%b addr=%h exp 1/10", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL br_gap got=%b exp=0", out_valid); end
    drain(20, cyc, to);
    checks++; if (to || cyc != 4) begin failures++; $display("FAIL br_drain cycles=%0d timeout=%0b exp=4", cyc, to); end
  endtask

  task automatic test_misaligned();
    int cyc; bit to;
    redirect_valid = 1'b1; redirect_target = 64'h12; out_ready = 1'b1;
    push_seq(64'h10, 2);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (misaligned_err !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misaligned_err); end
    checks++; if (imem_addr !== 64'h10) begin failures++; $display("FAIL mis_addr got=%h exp=10", imem_addr); end
    @(negedge clk);
    checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL mis_width got=%b exp=0", misaligned_err); end
    drain(20, cyc, to);
    checks++; if (to || cyc != 3) begin failures++; $display("FAIL mis_drain cycles=%0d timeout=%0b exp=3", cyc, to); end
  endtask

  task automatic test_redirect_full();
    int cyc; bit to; bit full;
    full = 1'b0;
    for (int i = 0; i < 12 && !full; i++) begin
      @(negedge clk);
      if (queue_count === 3'd4) full = 1'b1;
    end
    checks++; if (!full || imem_req !== 1'b0) begin failures++; $display("FAIL rf_fill full=%b req=%b exp 1/0", full, imem_req); end
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 64'h40; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || queue_count !== 3'd4) begin failures++; $display("FAIL rf_pre valid=%b count=%0d exp 1/4", out_valid, queue_count); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL rf_flush got=%0d exp=0", queue_count); end
    push_seq(64'h40, 2);
    drain(20, cyc, to);
    checks++; if (to || cyc != 4) begin failures++; $display("FAIL rf_drain cycles=%0d timeout=%0b exp=4", cyc, to); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; bit hit;
    apply_reset();
    reset = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (queue_count === 3'd3) hit = 1'b1;
    end
    checks++; if (!hit || imem_req !== 1'b0) begin failures++; $display("FAIL rm_setup hit=%b req=%b exp 1/0", hit, imem_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    push_seq(64'h0, 3);
    @(negedge clk);
    checks++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rm_empty count=%0d valid=%b exp 0/0", queue_count, out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin failures++; $display("FAIL rm_restart req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    drain(20, cyc, to);
    checks++; if (to || cyc != 5) begin failures++; $display("FAIL rm_drain cycles=%0d timeout=%0b exp=5", cyc, to); end
  endtask

  task automatic test_pc_wrap();
    int cyc; bit to;
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; out_ready = 1'b1;
    push_seq(64'hFFFF_FFFF_FFFF_FFFC, 3);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain(20, cyc, to);
    checks++; if (to || cyc != 5) begin failures++; $display("FAIL wrap_drain cycles=%0d timeout=%0b exp=5", cyc, to); end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0; redirect_target = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_misaligned();
    test_redirect_full();
    test_reset_mid();
    test_pc_wrap();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
